mem_stall_ctrl: RTL and testbench

Data-memory access sequencer for the 5-stage pipeline.
- Sits between the EX/MEM pipeline register outputs and a multi-cycle data memory with a req/ack handshake.
- When the instruction in MEM performs a load or store, it freezes PC, IF/ID, ID/EX and EX/MEM, and injects bubbles into MEM/WB until the memory acknowledges.
- Also provides a timeout guard and a saturating stall-cycle performance counter.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/sat_counter.sv | 34 +++
 rtl/mem_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared types and defaults for the 5-stage pipeline memory-access
//           sequencer: FSM state encoding, default timeout and perf-counter
//           widths, and the MEM/WB bubble control encoding.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Memory-access sequencer state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Defaults for the sequencer parameters
    localparam int unsigned MAX_WAIT_DEF = 64;
    localparam int unsigned CNT_W_DEF    = 16;

    // MEM/WB control fields zeroed when a bubble is injected
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam wb_ctrl_t BUBBLE_CTRL = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Saturating up-counter for performance monitoring. Counts cycles
//           with en=1 and holds at all-ones instead of wrapping.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset (clears count)
//           en    - count enable
//           count - current count value
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_stall_ctrl
// Purpose : Data-memory access sequencer for the 5-stage pipeline. Launches a
//           req/ack transaction for a load/store in MEM, stalls the front of
//           the pipeline and bubbles MEM/WB until the memory acknowledges or a
//           timeout expires. Counts stalled cycles (saturating).
// Ports   : clk_i, rst_i (async, active-low)
//           start_i, MemRead_i, MemWrite_i, addr_i, wdata_i - EX/MEM side
//           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//           mem_ack_i, mem_rdata_i                       - memory side
//           rdata_o, stall_o, bubble_o                   - pipeline control
//           timeout_o, stall_cnt_o                       - status / perf
// Revision: 1.0 - initial release
// ============================================================================
module mem_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_timeout;
    logic              w_access;
    logic              w_wait_last;
    logic              w_stall;
    logic              w_req;

    // Gated by reset so the pipeline is not held while the block is in reset.
    assign w_access    = rst_i & start_i & (MemRead_i | MemWrite_i);
    assign w_wait_last = (r_wait == c_WAIT_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            IDLE: begin
                // Stall in the detect cycle so EX/MEM holds the access stable.
                w_stall = w_access;
                if (w_access) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (mem_ack_i || w_wait_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // The finished access is still on EX/MEM here; it must not
                // be re-launched, so go straight back to IDLE.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Transaction registers, wait counter, read data and timeout flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_wait    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_we    <= MemWrite_i;  // read+write resolves to write
                        r_wait  <= '0;
                    end
                end
                BUSY: begin
                    r_wait <= r_wait + WAIT_W'(1);
                    // Ack takes priority over an expiring wait counter.
                    if (mem_ack_i) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                    end else if (w_wait_last) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (w_stall),
        .count (stall_cnt_o)
    );

    assign mem_req_o   = w_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign rdata_o     = r_rdata;
    assign stall_o     = w_stall;
    assign bubble_o    = w_stall;
    assign timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stall_ctrl
// Purpose : Self-checking bench for mem_stall_ctrl (MAX_WAIT=4, CNT_W=4 so
//           timeout and counter saturation are reachable in a short run).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stall_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        bubble_o;
    logic        timeout_o;
    logic [3:0]  stall_cnt_o;

    int passed;
    int total;

    mem_stall_ctrl #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4),
        .CNT_W    (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .bubble_o    (bubble_o),
        .timeout_o   (timeout_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        start;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdin;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_to;
        logic [3:0]  e_cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic s, input logic r, input logic w,
        input logic [31:0] a, input logic [31:0] wd,
        input logic k, input logic [31:0] rin,
        input logic es, input logic eq, input logic ew,
        input logic [31:0] ea, input logic [31:0] ewd,
        input logic [31:0] erd, input logic eto, input logic [3:0] ec);
        vec_t v;
        v.start = s;   v.rd = r;     v.wr = w;
        v.addr = a;    v.wdata = wd; v.ack = k;  v.rdin = rin;
        v.e_stall = es; v.e_req = eq; v.e_we = ew;
        v.e_addr = ea; v.e_wdata = ewd; v.e_rdata = erd;
        v.e_to = eto;  v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic k, input logic [31:0] rin);
        start_i = s; MemRead_i = r; MemWrite_i = w;
        addr_i = a;  wdata_i = wd;  mem_ack_i = k; mem_rdata_i = rin;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_i  = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        //           s  r  w  addr        wdata  ack rdata_in       stall req we  e_addr      e_wdata e_rdata        to cnt
        // load, ack on 3rd BUSY cycle
        vecs[0]  = mk(1, 1, 0, 32'h100, 32'h0,  0, 32'h0,          1, 0, 0, 32'h0,   32'h0,  32'h0,          0, 4'd0);
        vecs[1]  = mk(1, 1, 0, 32'h100, 32'h0,  0, 32'h0,          1, 1, 0, 32'h100, 32'h0,  32'h0,          0, 4'd1);
        vecs[2]  = mk(1, 1, 0, 32'h100, 32'h0,  0, 32'h0,          1, 1, 0, 32'h100, 32'h0,  32'h0,          0, 4'd2);
        vecs[3]  = mk(1, 1, 0, 32'h100, 32'h0,  1, 32'hCAFE_0001,  1, 1, 0, 32'h100, 32'h0,  32'h0,          0, 4'd3);
        vecs[4]  = mk(1, 1, 0, 32'h100, 32'h0,  0, 32'h0,          0, 0, 0, 32'h100, 32'h0,  32'hCAFE_0001,  0, 4'd4);
        // store, immediate ack; rdata_o must not change
        vecs[5]  = mk(1, 0, 1, 32'h204, 32'h55, 0, 32'h0,          1, 0, 0, 32'h100, 32'h0,  32'hCAFE_0001,  0, 4'd4);
        vecs[6]  = mk(1, 0, 1, 32'h204, 32'h55, 1, 32'hDEAD_BEEF,  1, 1, 1, 32'h204, 32'h55, 32'hCAFE_0001,  0, 4'd5);
        vecs[7]  = mk(1, 0, 1, 32'h204, 32'h55, 0, 32'h0,          0, 0, 1, 32'h204, 32'h55, 32'hCAFE_0001,  0, 4'd6);
        // back-to-back loads; stray ack in DONE is ignored
        vecs[8]  = mk(1, 1, 0, 32'h300, 32'h0,  0, 32'h0,          1, 0, 1, 32'h204, 32'h55, 32'hCAFE_0001,  0, 4'd6);
        vecs[9]  = mk(1, 1, 0, 32'h300, 32'h0,  1, 32'h1111_2222,  1, 1, 0, 32'h300, 32'h0,  32'hCAFE_0001,  0, 4'd7);
        vecs[10] = mk(1, 1, 0, 32'h300, 32'h0,  1, 32'hFFFF_FFFF,  0, 0, 0, 32'h300, 32'h0,  32'h1111_2222,  0, 4'd8);
        vecs[11] = mk(1, 1, 0, 32'h304, 32'h0,  0, 32'h0,          1, 0, 0, 32'h300, 32'h0,  32'h1111_2222,  0, 4'd8);
        vecs[12] = mk(1, 1, 0, 32'h304, 32'h0,  1, 32'h3333_4444,  1, 1, 0, 32'h304, 32'h0,  32'h1111_2222,  0, 4'd9);
        vecs[13] = mk(1, 1, 0, 32'h304, 32'h0,  0, 32'h0,          0, 0, 0, 32'h304, 32'h0,  32'h3333_4444,  0, 4'd10);
        // start_i low in IDLE: no access; ack in IDLE ignored
        vecs[14] = mk(0, 1, 0, 32'h400, 32'h0,  0, 32'h0,          0, 0, 0, 32'h304, 32'h0,  32'h3333_4444,  0, 4'd10);
        vecs[15] = mk(0, 1, 0, 32'h400, 32'h0,  1, 32'h5555_5555,  0, 0, 0, 32'h304, 32'h0,  32'h3333_4444,  0, 4'd10);
        // start_i drops during BUSY, ack on 2nd BUSY cycle
        vecs[16] = mk(1, 1, 0, 32'h500, 32'h0,  0, 32'h0,          1, 0, 0, 32'h304, 32'h0,  32'h3333_4444,  0, 4'd10);
        vecs[17] = mk(0, 1, 0, 32'h500, 32'h0,  0, 32'h0,          1, 1, 0, 32'h500, 32'h0,  32'h3333_4444,  0, 4'd11);
        vecs[18] = mk(0, 1, 0, 32'h500, 32'h0,  1, 32'h6666_7777,  1, 1, 0, 32'h500, 32'h0,  32'h3333_4444,  0, 4'd12);
        vecs[19] = mk(0, 1, 0, 32'h500, 32'h0,  0, 32'h0,          0, 0, 0, 32'h500, 32'h0,  32'h6666_7777,  0, 4'd13);
        // no ack: timeout after 4 BUSY cycles; counter saturates at 15
        vecs[20] = mk(1, 1, 0, 32'h600, 32'h0,  0, 32'h0,          1, 0, 0, 32'h500, 32'h0,  32'h6666_7777,  0, 4'd13);
        vecs[21] = mk(1, 1, 0, 32'h600, 32'h0,  0, 32'h0,          1, 1, 0, 32'h600, 32'h0,  32'h6666_7777,  0, 4'd14);
        vecs[22] = mk(1, 1, 0, 32'h600, 32'h0,  0, 32'h0,          1, 1, 0, 32'h600, 32'h0,  32'h6666_7777,  0, 4'd15);
        vecs[23] = mk(1, 1, 0, 32'h600, 32'h0,  0, 32'h0,          1, 1, 0, 32'h600, 32'h0,  32'h6666_7777,  0, 4'd15);
        vecs[24] = mk(1, 1, 0, 32'h600, 32'h0,  0, 32'h0,          1, 1, 0, 32'h600, 32'h0,  32'h6666_7777,  0, 4'd15);
        vecs[25] = mk(1, 1, 0, 32'h600, 32'h0,  0, 32'h0,          0, 0, 0, 32'h600, 32'h0,  32'h0,          1, 4'd15);
        vecs[26] = mk(0, 0, 0, 32'h600, 32'h0,  0, 32'h0,          0, 0, 0, 32'h600, 32'h0,  32'h0,          1, 4'd15);

        // Reset state
        #1;
        chk("reset_req",     -1, 32'(mem_req_o),   32'h0);
        chk("reset_stall",   -1, 32'(stall_o),     32'h0);
        chk("reset_addr",    -1, mem_addr_o,       32'h0);
        chk("reset_rdata",   -1, rdata_o,          32'h0);
        chk("reset_timeout", -1, 32'(timeout_o),   32'h0);
        chk("reset_cnt",     -1, 32'(stall_cnt_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            drive(vecs[i].start, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                  vecs[i].wdata, vecs[i].ack, vecs[i].rdin);
            #1;
            chk("stall",   i, 32'(stall_o),     32'(vecs[i].e_stall));
            chk("bubble",  i, 32'(bubble_o),    32'(vecs[i].e_stall));
            chk("req",     i, 32'(mem_req_o),   32'(vecs[i].e_req));
            chk("we",      i, 32'(mem_we_o),    32'(vecs[i].e_we));
            chk("addr",    i, mem_addr_o,       vecs[i].e_addr);
            chk("wdata",   i, mem_wdata_o,      vecs[i].e_wdata);
            chk("rdata",   i, rdata_o,          vecs[i].e_rdata);
            chk("timeout", i, 32'(timeout_o),   32'(vecs[i].e_to));
            chk("cnt",     i, 32'(stall_cnt_o), 32'(vecs[i].e_cnt));
        end

        // Asynchronous reset in the middle of BUSY
        @(negedge clk_i);
        drive(1, 1, 0, 32'h700, 32'h0, 0, 32'h0);
        #1;
        chk("mid_detect_stall", 100, 32'(stall_o), 32'h1);
        @(negedge clk_i);
        #1;
        chk("mid_busy_req", 101, 32'(mem_req_o), 32'h1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_req",     102, 32'(mem_req_o),   32'h0);
        chk("mid_rst_stall",   102, 32'(stall_o),     32'h0);
        chk("mid_rst_cnt",     102, 32'(stall_cnt_o), 32'h0);
        chk("mid_rst_timeout", 102, 32'(timeout_o),   32'h0);
        chk("mid_rst_addr",    102, mem_addr_o,       32'h0);
        chk("mid_rst_we",      102, 32'(mem_we_o),    32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        chk("post_rst_stall", 103, 32'(stall_o),   32'h0);
        chk("post_rst_req",   103, 32'(mem_req_o), 32'h0);

        // New load from IDLE; ack coincides with the last allowed wait cycle
        @(negedge clk_i);
        drive(1, 1, 0, 32'h800, 32'h0, 0, 32'h0);
        #1;
        chk("idle_detect_stall", 104, 32'(stall_o),   32'h1);
        chk("idle_detect_req",   104, 32'(mem_req_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            mem_ack_i   = (k == 3);
            mem_rdata_i = 32'hABCD_0123;
            #1;
            chk("edge_busy_req",   105 + k, 32'(mem_req_o), 32'h1);
            chk("edge_busy_stall", 105 + k, 32'(stall_o),   32'h1);
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        chk("edge_done_req",     110, 32'(mem_req_o),   32'h0);
        chk("edge_done_stall",   110, 32'(stall_o),     32'h0);
        chk("edge_done_rdata",   110, rdata_o,          32'hABCD_0123);
        chk("edge_done_timeout", 110, 32'(timeout_o),   32'h0);
        chk("edge_done_cnt",     110, 32'(stall_cnt_o), 32'h5);
        chk("edge_done_addr",    110, mem_addr_o,       32'h800);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
